ssd_display_sched: RTL and testbench
====================================

// Module: ssd_display_sched
// PURPOSE
//  - Scheduler/controller for the 4-digit seven-segment display.
//  - Shares the display between NUM_SRC 13-bit debug values (e.g. PC, ALU result, reg data, instr count).
//  - Selects one source, converts it to BCD with a sequential shift-add-3 (no divide/modulo),
//    latches the digits tear-free and time-multiplexes the anodes.
//  - Sits between the core's debug taps and the board SSD pins.
// PARAMETERS
//  NUM_SRC       4    number of 13-bit sources; power of 2, 2..8
//  REFRESH_BITS  20   refresh counter width; digit slot = counter[REFRESH_BITS-1:REFRESH_BITS-2]
// PORTS
//  clk       in   1             system clock, all logic on rising edge
//  rst       in   1             synchronous, active-high reset
//  src_data  in   NUM_SRC*13    packed sources; source k = src_data[13*k +: 13]
//  next_btn  in   1             level, already debounced; rising edge advances source
//  src_idx   out  $clog2(NUM_SRC)  index of source currently displayed
//  conv_busy out  1             high while a BCD conversion is in flight
//  Anode     out  4             active-low digit enables, 0111 = thousands .. 1110 = units
//  LED_out   out  7             active-low segments {a,b,c,d,e,f,g}, MSB = a
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - src_idx=0, conv_busy=0, Anode=4'b1111, LED_out=7'b1111111.
//   - Refresh counter=0, digit latch=16'h0000, btn edge register=0, FSM=IDLE.
//   - Reset mid-conversion discards the partial result; the latch keeps no stale value.
//  Source select:
//   - Rising edge of next_btn (registered compare): src_idx <= src_idx+1, wraps NUM_SRC-1 -> 0.
//   - Held button = one step only.
//  Conversion FSM (IDLE, LOAD, SHIFT, DONE):
//   - IDLE->LOAD when start is asserted.
//     start = refresh counter wraps to 0, OR src_idx changed last cycle, OR first cycle after reset.
//   - LOAD (1 cyc): capture src_data[src_idx] into 13-bit shift reg; clear 16-bit BCD accumulator.
//   - SHIFT (13 cyc): each BCD nibble >=5 gets +3, then shift {bcd,bin} left by 1.
//   - DONE (1 cyc): digit latch <= BCD accumulator; ->IDLE.
//   - Latency: start to new digits visible = 15 cycles. conv_busy=1 in LOAD, SHIFT, DONE.
//   - Source changes mid-process are ignored after LOAD (value sampled once).
//   - start during LOAD/SHIFT/DONE: abort, go to LOAD next cycle. The latch is NOT updated by
//     the aborted run.
//   - Max input 8191 < 9999, so no saturation is needed. Thousands nibble is 0..8.
//  Scan:
//   - Refresh counter increments every cycle and wraps.
//   - Slots 00/01/10/11 drive Anode 0111/1011/1101/1110 with latch digits [15:12]/[11:8]/[7:4]/[3:0].
//   - Anode and LED_out are registered: 1 cycle after the slot change.
//  Segment codes:
//   - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
//   - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
//   - Any other nibble = 1111111 (blank).
// CONFIGURATION
//  SSD_LEAD_BLANK_EN defined:
//   - Leading zero digits show 1111111 (their anode still pulses). Units digit is never blanked.
//   - Value 0 shows "   0"; 42 shows "  42".
//  Not defined: all four digits always shown ("0042").
// TESTING (REFRESH_BITS=4 in sim)
//  1 rst high 3 cyc, src0=13'd1234 -> Anode=1111/LED=1111111 during rst;
//    conv_busy high 15 cyc; then slots 0..3 show 1,2,3,4.
//  2 src0=13'd8191 -> digits 8,1,9,1 (0000000,1001111,0000100,1001111); no X on any output.
//  3 next_btn held high 40 cyc with src1=13'd7 -> src_idx 0->1 exactly once;
//    digits 0,0,0,7 (or blank,blank,blank,7 with SSD_LEAD_BLANK_EN).
//  4 next_btn edge at SHIFT cycle 6 of a src0 conversion -> abort, LOAD next cycle;
//    latch never holds src0's partial value; final digits = src1.
//  5 NUM_SRC=4, four button edges -> src_idx 1,2,3,0 (wrap).
//  6 rst asserted mid-SHIFT -> next cycle conv_busy=0, Anode=1111;
//    after release, a fresh conversion completes in 15 cyc.

Source files
------------

// File: rtl/ssd_display_sched.sv
// rtl/ssd_display_sched.sv - four-digit seven-segment display scheduler with sequential BCD conversion
//
// Shares one 4-digit display between NUM_SRC 13-bit debug values. A debounced
// button steps through the sources. The selected value is converted to BCD by
// a shift-add-3 engine, and the digits are latched only when a conversion
// completes. The anodes are scanned from the top bits of a free-running
// refresh counter.
//
// Optional feature macro: SSD_LEAD_BLANK_EN (blank leading zero digits)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   src_data   packed sources, source k = src_data[13*k +: 13]
//   next_btn   debounced level, a rising edge advances the source index
//   src_idx    index of the source being displayed
//   conv_busy  high while a BCD conversion is in flight
//   Anode      active-low digit enables, 0111 = thousands .. 1110 = units
//   LED_out    active-low segments {a,b,c,d,e,f,g}

module ssd_display_sched #(
   parameter int NUM_SRC      = 4,
   parameter int REFRESH_BITS = 20,
   localparam int IW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC*13-1:0]   src_data,
   input  logic                    next_btn,
   output logic [IW-1:0]           src_idx,
   output logic                    conv_busy,
   output logic [3:0]              Anode,
   output logic [6:0]              LED_out
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t                  state, state_next;
   logic [REFRESH_BITS-1:0] refresh;
   logic                    btn_q;
   logic                    btn_rise;
   logic                    idx_chg;
   logic                    boot;
   logic                    start;
   logic [12:0]             sel_data;
   logic [12:0]             bin;
   logic [15:0]             bcd;
   logic [15:0]             bcd_adj;
   logic [28:0]             shifted;
   logic [3:0]              shift_cnt;
   logic [15:0]             latch;
   logic [1:0]              slot;
   logic [3:0]              digit;
   logic [3:0]              anode_next;
   logic                    blank;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   assign btn_rise  = next_btn & ~btn_q;
   // A new conversion begins on every refresh wrap, right after a source
   // change, and once after reset so the display never waits a full period.
   assign start     = boot | idx_chg | (refresh == '0);
   assign conv_busy = (state != IDLE);
   assign slot      = refresh[REFRESH_BITS-1 -: 2];
   assign shifted   = {bcd_adj, bin} << 1;

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_idx == IW'(k)) sel_data = src_data[13*k +: 13];
      end
   end

   // Add-3 correction applied before each shift keeps every nibble decimal.
   always_comb begin
      bcd_adj = bcd;
      for (int n = 0; n < 4; n++) begin
         if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
   end

   // Any start restarts the engine, which is how a run is aborted.
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = LOAD;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            LOAD:    state_next = SHIFT;
            SHIFT:   state_next = (shift_cnt == 4'd12) ? DONE : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      anode_next = 4'b1111;
      digit      = 4'd0;
      blank      = 1'b0;
      case (slot)
         2'd0: begin anode_next = 4'b0111; digit = latch[15:12]; end
         2'd1: begin anode_next = 4'b1011; digit = latch[11:8];  end
         2'd2: begin anode_next = 4'b1101; digit = latch[7:4];   end
         default: begin anode_next = 4'b1110; digit = latch[3:0]; end
      endcase
`ifdef SSD_LEAD_BLANK_EN
      // A digit is a leading zero when it and every digit above it is zero;
      // the units digit is always shown.
      case (slot)
         2'd0:    blank = (latch[15:12] == 4'd0);
         2'd1:    blank = (latch[15:8] == 8'd0);
         2'd2:    blank = (latch[15:4] == 12'd0);
         default: blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh   <= '0;
         btn_q     <= 1'b0;
         idx_chg   <= 1'b0;
         boot      <= 1'b1;
         src_idx   <= '0;
         state     <= IDLE;
         bin       <= '0;
         bcd       <= '0;
         shift_cnt <= '0;
         latch     <= '0;
         Anode     <= 4'b1111;
         LED_out   <= 7'b1111111;
      end else begin
         refresh <= refresh + 1'b1;
         btn_q   <= next_btn;
         idx_chg <= btn_rise;
         boot    <= 1'b0;
         if (btn_rise) src_idx <= src_idx + IW'(1);
         state <= state_next;
         case (state)
            LOAD: begin
               bin       <= sel_data;
               bcd       <= '0;
               shift_cnt <= '0;
            end
            SHIFT: begin
               bcd       <= shifted[28:13];
               bin       <= shifted[12:0];
               shift_cnt <= shift_cnt + 4'd1;
            end
            DONE: begin
               // An aborted run must not publish its result.
               if (!start) latch <= bcd;
            end
            default: ;
         endcase
         Anode   <= anode_next;
         LED_out <= blank ? 7'b1111111 : seg7(digit);
      end
   end

endmodule

// File: tb/tb_ssd_display_sched.sv
// tb/tb_ssd_display_sched.sv - directed self-checking bench for ssd_display_sched

module tb_ssd_display_sched;

   localparam int NUM_SRC      = 4;
   localparam int REFRESH_BITS = 4;

   localparam logic [6:0] C0 = 7'b0000001;
   localparam logic [6:0] C1 = 7'b1001111;
   localparam logic [6:0] C2 = 7'b0010010;
   localparam logic [6:0] C3 = 7'b0000110;
   localparam logic [6:0] C4 = 7'b1001100;
   localparam logic [6:0] C5 = 7'b0100100;
   localparam logic [6:0] C6 = 7'b0100000;
   localparam logic [6:0] C7 = 7'b0001111;
   localparam logic [6:0] C8 = 7'b0000000;
   localparam logic [6:0] C9 = 7'b0000100;
   localparam logic [6:0] BL = 7'b1111111;
`ifdef SSD_LEAD_BLANK_EN
   localparam logic [6:0] ZL = BL;
`else
   localparam logic [6:0] ZL = C0;
`endif

   logic                  clk;
   logic                  rst;
   logic [NUM_SRC*13-1:0] src_data;
   logic                  next_btn;
   logic [1:0]            src_idx;
   logic                  conv_busy;
   logic [3:0]            Anode;
   logic [6:0]            LED_out;

   int checks = 0;
   int errors = 0;

   ssd_display_sched #(
      .NUM_SRC      (NUM_SRC),
      .REFRESH_BITS (REFRESH_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .src_data  (src_data),
      .next_btn  (next_btn),
      .src_idx   (src_idx),
      .conv_busy (conv_busy),
      .Anode     (Anode),
      .LED_out   (LED_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end, time %0t", $time);
      $fatal(1);
   end

   // Lets the display settle, then records the last segment pattern seen for each anode.
   task automatic capture(output logic [27:0] segs, output bit saw_x);
      segs  = 'x;
      saw_x = 1'b0;
      repeat (36) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ($isunknown({Anode, LED_out, conv_busy, src_idx})) saw_x = 1'b1;
         case (Anode)
            4'b0111: segs[27:21] = LED_out;
            4'b1011: segs[20:14] = LED_out;
            4'b1101: segs[13:7]  = LED_out;
            4'b1110: segs[6:0]   = LED_out;
            default: ;
         endcase
      end
   endtask

   task automatic test_reset;
      logic [27:0] segs;
      bit          sx;
      int          busy_cnt;
      rst      = 1'b1;
      next_btn = 1'b0;
      src_data = '0;
      src_data[12:0] = 13'd1234;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (Anode !== 4'b1111) begin errors++; $display("FAIL reset_anode: got %b expected 1111", Anode); end
      checks++; if (LED_out !== BL) begin errors++; $display("FAIL reset_led: got %b expected %b", LED_out, BL); end
      checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", conv_busy); end
      checks++; if (src_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", src_idx); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (conv_busy !== 1'b1) begin errors++; $display("FAIL boot_busy: got %b expected 1", conv_busy); end
      checks++; if (Anode !== 4'b0111 || LED_out !== ZL) begin
         errors++; $display("FAIL boot_digit: got anode %b led %b expected anode 0111 led %b", Anode, LED_out, ZL);
      end
      busy_cnt = conv_busy ? 1 : 0;
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         if (conv_busy) busy_cnt++;
      end
      checks++; if (busy_cnt != 15) begin errors++; $display("FAIL boot_busy_len: got %0d expected 15", busy_cnt); end
      capture(segs, sx);
      checks++; if (segs !== {C1, C2, C3, C4}) begin errors++; $display("FAIL digits_1234: got %b expected %b", segs, {C1, C2, C3, C4}); end
   endtask

   task automatic test_max_value;
      logic [27:0] segs;
      bit          sx;
      src_data[12:0] = 13'd8191;
      capture(segs, sx);
      checks++; if (segs !== {C8, C1, C9, C1}) begin errors++; $display("FAIL digits_8191: got %b expected %b", segs, {C8, C1, C9, C1}); end
      checks++; if (sx) begin errors++; $display("FAIL no_x: got unknown on outputs expected none"); end
   endtask

   task automatic test_held_button;
      logic [27:0] segs;
      bit          sx;
      logic [1:0]  prev;
      int          changes;
      src_data[25:13] = 13'd7;
      prev    = src_idx;
      changes = 0;
      @(negedge clk);
      next_btn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (src_idx !== prev) changes++;
         prev = src_idx;
      end
      checks++; if (changes != 1) begin errors++; $display("FAIL held_steps: got %0d expected 1", changes); end
      checks++; if (src_idx !== 2'd1) begin errors++; $display("FAIL held_idx: got %0d expected 1", src_idx); end
      next_btn = 1'b0;
      capture(segs, sx);
      checks++; if (segs !== {ZL, ZL, ZL, C7}) begin errors++; $display("FAIL digits_7: got %b expected %b", segs, {ZL, ZL, ZL, C7}); end
   endtask

   task automatic test_wrap;
      logic [1:0] exp_idx [4];
      exp_idx = '{2'd1, 2'd2, 2'd3, 2'd0};
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         next_btn = 1'b1;
         @(negedge clk);
         checks++; if (src_idx !== exp_idx[k]) begin errors++; $display("FAIL wrap_idx%0d: got %0d expected %0d", k, src_idx, exp_idx[k]); end
         next_btn = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_abort;
      logic [27:0] segs;
      bit          sx;
      bit          f0, f1;
      int          busy_cnt, bad_led;
      logic [6:0]  exp_led;
      src_data[12:0]  = 13'd4321;
      src_data[25:13] = 13'd56;
      repeat (40) @(negedge clk);
      f0 = 1'b0; f1 = 1'b0;
      for (int i = 0; i < 40 && !f0; i++) begin @(negedge clk); if (!conv_busy) f0 = 1'b1; end
      for (int i = 0; i < 40 && f0 && !f1; i++) begin @(negedge clk); if (conv_busy) f1 = 1'b1; end
      checks++; if (!f1) begin errors++; $display("FAIL abort_sync: got no conversion start expected one within 40 cycles"); return; end
      busy_cnt = 0;
      bad_led  = 0;
      for (int s = 0; s < 32; s++) begin
         if (s > 0) @(negedge clk);
         if (s < 31 && conv_busy) busy_cnt++;
         if (s == 31) begin
            checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b expected 0", conv_busy); end
         end
         case (Anode)
            4'b0111: exp_led = C4;
            4'b1011: exp_led = C3;
            4'b1101: exp_led = C2;
            4'b1110: exp_led = C1;
            default: exp_led = 7'bx;
         endcase
         if (LED_out !== exp_led) bad_led++;
         if (s == 6) next_btn = 1'b1;
         if (s == 8) next_btn = 1'b0;
      end
      checks++; if (busy_cnt != 31) begin errors++; $display("FAIL abort_busy_len: got %0d expected 31", busy_cnt); end
      checks++; if (bad_led != 0) begin errors++; $display("FAIL abort_latch_held: got %0d off samples expected 0", bad_led); end
      checks++; if (src_idx !== 2'd1) begin errors++; $display("FAIL abort_idx: got %0d expected 1", src_idx); end
      capture(segs, sx);
      checks++; if (segs !== {ZL, ZL, C5, C6}) begin errors++; $display("FAIL digits_56: got %b expected %b", segs, {ZL, ZL, C5, C6}); end
   endtask

   task automatic test_reset_mid_shift;
      logic [27:0] segs;
      bit          sx;
      bit          f0, f1;
      int          busy_cnt, stale;
      f0 = 1'b0; f1 = 1'b0;
      for (int i = 0; i < 40 && !f0; i++) begin @(negedge clk); if (!conv_busy) f0 = 1'b1; end
      for (int i = 0; i < 40 && f0 && !f1; i++) begin @(negedge clk); if (conv_busy) f1 = 1'b1; end
      checks++; if (!f1) begin errors++; $display("FAIL rst_sync: got no conversion start expected one within 40 cycles"); return; end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", conv_busy); end
      checks++; if (Anode !== 4'b1111) begin errors++; $display("FAIL rst_mid_anode: got %b expected 1111", Anode); end
      checks++; if (src_idx !== 2'd0) begin errors++; $display("FAIL rst_mid_idx: got %0d expected 0", src_idx); end
      rst = 1'b0;
      busy_cnt = 0;
      stale    = 0;
      for (int s = 0; s < 16; s++) begin
         @(negedge clk);
         if (conv_busy) busy_cnt++;
         if (Anode == 4'b1110 && LED_out !== C0) stale++;
      end
      checks++; if (busy_cnt != 15) begin errors++; $display("FAIL rst_busy_len: got %0d expected 15", busy_cnt); end
      checks++; if (stale != 0) begin errors++; $display("FAIL rst_stale_units: got %0d non-zero units samples expected 0", stale); end
      capture(segs, sx);
      checks++; if (segs !== {C4, C3, C2, C1}) begin errors++; $display("FAIL digits_4321: got %b expected %b", segs, {C4, C3, C2, C1}); end
   endtask

   initial begin
      rst      = 1'b1;
      next_btn = 1'b0;
      src_data = '0;
      test_reset();
      test_max_value();
      test_held_button();
      test_wrap();
      test_abort();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
